// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite read-side definitions: FSM state encoding, RRESP codes and
// the byte-to-word shift used when forming table addresses.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned WORD_SHIFT = 2;

endpackage : axi_lite_pkg

// File: rtl/axi_times_table.sv
// Times-table lookup: {a, b} indexes a word table read over AXI4-Lite.
// Optional macro MULT_CHECK_EN adds a local multiplier that flags wrong table entries on err.
module axi_times_table
  import axi_lite_pkg::*;
#(
  parameter int          OP_W      = 3,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [2*OP_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              err,
  output logic [31:0]       m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  localparam int RES_W = 2 * OP_W;

  state_e             state_q, state_d;
  logic [31:0]        araddr_q, araddr_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic               req_hs, rd_hs;

  assign req_hs = (state_q == IDLE) && req_valid;
  assign rd_hs  = (state_q == DATA) && m_rvalid;

  // NOTE: sequential state uses non-blocking assignments only; mixing in
  // blocking assignments here creates simulation/synthesis ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb assigns its outputs a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)    state_d = ADDR;
      ADDR:    if (m_arready)    state_d = DATA;
      DATA:    if (m_rvalid)     state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == IDLE);
    m_arvalid    = (state_q == ADDR);
    m_rready     = (state_q == DATA);
    result_valid = (state_q == DONE);
  end

  // Address is captured once at acceptance so later operand changes cannot disturb it.
  always_comb begin
    araddr_d = araddr_q;
    result_d = result_q;
    err_d    = err_q;
    if (req_hs) begin
      araddr_d = BASE_ADDR + (32'({a, b}) << WORD_SHIFT);
    end
    if (rd_hs) begin
      result_d = m_rdata[RES_W-1:0];
      err_d    = (m_rresp != RESP_OKAY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      araddr_q <= araddr_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Upper table bits carry no product information for this operand width.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^m_rdata[31:RES_W];

  assign m_araddr = araddr_q;
  assign result   = result_q;

`ifdef MULT_CHECK_EN
  logic [OP_W-1:0]  a_q, b_q;
  logic [RES_W-1:0] product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (req_hs) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign product = RES_W'(a_q) * RES_W'(b_q);
  assign err     = err_q | ((state_q == DONE) && (product != result_q));
`else
  assign err = err_q;
`endif

endmodule : axi_times_table

// File: tb/tb_axi_times_table.sv
// Self-checking bench for axi_times_table: table-driven transactions against a
// lock-step AXI4-Lite slave, a scoreboard queue, and a reset-during-DATA sequence.
module tb_axi_times_table;

  localparam int          OP_W  = 3;
  localparam int          RES_W = 2 * OP_W;
  localparam logic [31:0] BASE  = 32'h0000_0000;

`ifdef MULT_CHECK_EN
  localparam logic MC_ERR = 1'b1;
`else
  localparam logic MC_ERR = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [OP_W-1:0]   a, b;
  logic              req_valid, req_ready;
  logic [RES_W-1:0]  result;
  logic              result_valid, result_ready, err;
  logic [31:0]       m_araddr;
  logic              m_arvalid, m_arready;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid, m_rready;

  axi_times_table #(.OP_W(OP_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b),
    .req_valid(req_valid), .req_ready(req_ready),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .err(err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    int               ar_dly;
    int               r_dly;
    int               rr_dly;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic [31:0]      exp_addr;
    logic [RES_W-1:0] exp_result;
    logic             exp_err;
  } vec_t;

  typedef struct {
    logic [31:0]      addr;
    logic [RES_W-1:0] result;
    logic             err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; the slave stalls AR, R and the consumer stalls
  // result_ready for the cycle counts held in the vector.
  task automatic run_txn(input vec_t v);
    exp_t e;
    e.addr   = v.exp_addr;
    e.result = v.exp_result;
    e.err    = v.exp_err;
    a = v.a;
    b = v.b;
    req_valid = 1'b1;
    check("req_ready_idle", req_ready, 1);
    sb_q.push_back(e);
    next_cycle();
    req_valid = 1'b0;
    a = ~v.a;
    b = ~v.b;

    for (int i = 0; i <= v.ar_dly; i++) begin
      m_arready = (i == v.ar_dly);
      m_rvalid  = (i == 0) && (v.ar_dly > 0);
      m_rdata   = 32'hFFFF_FFFF;
      check("arvalid_held", m_arvalid, 1);
      check("araddr_stable", m_araddr, v.exp_addr);
      check("rready_in_addr", m_rready, 0);
      check("req_ready_busy", req_ready, 0);
      next_cycle();
    end
    m_arready = 1'b0;
    m_rvalid  = 1'b0;

    for (int i = 0; i <= v.r_dly; i++) begin
      m_rvalid = (i == v.r_dly);
      m_rdata  = v.rdata | 32'hA5A5_A5C0;
      m_rresp  = v.rresp;
      check("arvalid_in_data", m_arvalid, 0);
      check("rready_in_data", m_rready, 1);
      check("result_valid_early", result_valid, 0);
      next_cycle();
    end
    m_rvalid = 1'b0;
    m_rdata  = 32'h1234_5677;
    m_rresp  = 2'b11;

    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got no entry expected one");
    end else begin
      e = sb_q.pop_front();
    end
    for (int i = 0; i <= v.rr_dly; i++) begin
      result_ready = (i == v.rr_dly);
      check("result_valid", result_valid, 1);
      check("result", result, e.result);
      check("err", err, e.err);
      check("rready_in_done", m_rready, 0);
      check("req_ready_done", req_ready, 0);
      if (v.rr_dly > 0) begin
        req_valid = 1'b1;
        a = 3'd7;
        b = 3'd7;
      end
      next_cycle();
    end
    result_ready = 1'b0;
    req_valid    = 1'b0;
    check("back_to_idle", req_ready, 1);
    check("result_valid_drop", result_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    //             a     b    ar r  rr rdata   rresp  addr          res     err
    vecs[0] = '{3'd3, 3'd7, 0, 0, 0, 32'd21, 2'b00, 32'h0000_007C, 6'd21, 1'b0};
    vecs[1] = '{3'd5, 3'd6, 4, 0, 0, 32'd30, 2'b00, 32'h0000_00B8, 6'd30, 1'b0};
    vecs[2] = '{3'd1, 3'd1, 0, 1, 0, 32'd0,  2'b10, 32'h0000_0024, 6'd0,  1'b1};
    vecs[3] = '{3'd6, 3'd3, 0, 0, 5, 32'd18, 2'b00, 32'h0000_00CC, 6'd18, 1'b0};
    vecs[4] = '{3'd2, 3'd4, 0, 0, 0, 32'd9,  2'b00, 32'h0000_0050, 6'd9,  MC_ERR};
    vecs[5] = '{3'd0, 3'd0, 1, 2, 1, 32'd0,  2'b11, 32'h0000_0000, 6'd0,  1'b1};
    vecs[6] = '{3'd7, 3'd7, 0, 0, 0, 32'd49, 2'b00, 32'h0000_00FC, 6'd49, 1'b0};

    rst_n = 1'b0;
    a = '0;
    b = '0;
    req_valid    = 1'b0;
    result_ready = 1'b0;
    m_arready    = 1'b0;
    m_rdata      = '0;
    m_rresp      = 2'b00;
    m_rvalid     = 1'b0;
    repeat (2) next_cycle();
    check("rst_arvalid", m_arvalid, 0);
    check("rst_rready", m_rready, 0);
    check("rst_araddr", m_araddr, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    check("rst_req_ready", req_ready, 1);
    next_cycle();

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Reset asserted mid-transaction while waiting for R data.
    a = 3'd4;
    b = 3'd5;
    req_valid = 1'b1;
    next_cycle();
    req_valid = 1'b0;
    m_arready = 1'b1;
    next_cycle();
    m_arready = 1'b0;
    check("pre_rst_rready", m_rready, 1);
    rst_n = 1'b0;
    #1;
    check("arst_rready", m_rready, 0);
    check("arst_arvalid", m_arvalid, 0);
    check("arst_araddr", m_araddr, 0);
    check("arst_result", result, 0);
    check("arst_result_valid", result_valid, 0);
    check("arst_err", err, 0);
    next_cycle();
    rst_n = 1'b1;
    check("post_rst_req_ready", req_ready, 1);
    v = '{3'd7, 3'd7, 0, 0, 0, 32'd49, 2'b00, 32'h0000_00FC, 6'd49, 1'b0};
    run_txn(v);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_axi_times_table

// File: doc/axi_times_table.md
AXI_TIMES_TABLE -- requirements
Module: axi_times_table

Interface
REQ-001 SHALL have parameter OP_W, default 3: operand width in bits, legal range 2..8.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of table entry 0.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port a, input, OP_W: multiplicand.
REQ-006 SHALL have port b, input, OP_W: multiplier.
REQ-007 SHALL have port req_valid, input, 1: lookup request.
REQ-008 SHALL have port req_ready, output, 1: block can accept a request.
REQ-009 SHALL have port result, output, 2*OP_W: product read from table.
REQ-010 SHALL have port result_valid, output, 1: result and err are valid.
REQ-011 SHALL have port result_ready, input, 1: consumer takes the result.
REQ-012 SHALL have port err, output, 1: RRESP non-OKAY, or check mismatch when enabled.
REQ-013 SHALL have AXI4-Lite read-master ports m_araddr (out, 32), m_arvalid (out, 1), m_arready (in, 1), m_rdata (in, 32), m_rresp (in, 2), m_rvalid (in, 1), m_rready (out, 1).

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, DATA, DONE.
REQ-015 SHALL assert req_ready only in IDLE. A handshake (req_valid && req_ready) latches a and b and moves the FSM to ADDR.
REQ-016 SHALL drive m_araddr = BASE_ADDR + ({a_lat, b_lat} << 2), word-addressed.
REQ-017 SHALL assert m_arvalid throughout ADDR and hold m_araddr stable until m_arready is sampled high, then move to DATA.
REQ-018 SHALL assert m_rready only in DATA. When m_rvalid is sampled high, it SHALL register result = m_rdata[2*OP_W-1:0] and err = (m_rresp != 2'b00), then move to DONE.
REQ-019 SHALL assert result_valid only in DONE, holding result and err stable until result_ready is sampled high, then return to IDLE.
REQ-020 SHALL give minimum request-to-result_valid latency of 3 cycles, with m_arready and m_rvalid high on the first cycle offered.
REQ-021 SHALL ignore changes on a and b after acceptance, and ignore req_valid outside IDLE.
REQ-022 SHALL ignore m_rvalid while in ADDR. m_rvalid before the AR handshake is a slave protocol violation.
REQ-023 SHALL, with OP_W=3, accept operands 0..7 on both inputs. The largest address is BASE_ADDR + 0xFC.

Reset
REQ-024 SHALL, on rst_n low, enter IDLE and clear result, result_valid, err, m_arvalid, m_rready and m_araddr to 0, with req_ready = 1 after release.
REQ-025 SHALL abandon any in-flight transaction on reset, with no response returned. The interconnect is reset by the same rst_n.

Configuration
REQ-026 SHALL, with MULT_CHECK_EN defined, compute a_lat*b_lat locally and, in DONE, OR (product != result) into err.
REQ-027 SHALL, without MULT_CHECK_EN, contain no multiplier logic, with err reflecting RRESP only.

Structure
REQ-028 SHALL take the FSM state enum, the RESP_OKAY/SLVERR/DECERR constants and the word-shift constant (2) from shared package axi_lite_pkg.
REQ-029 SHALL use a single flat module with no sub-modules.

Verification
REQ-030 SHALL cover reset then a=3, b=7, with slave ready immediately and m_rdata=21: m_araddr=0x7C, result=21, err=0, result_valid 3 cycles after the request.
REQ-031 SHALL cover slave holding m_arready low 4 cycles with a=5, b=6: m_arvalid held high and m_araddr=0xB8 stable throughout, then result=30.
REQ-032 SHALL cover m_rresp=2'b10 with m_rdata=0: err=1, result=0, FSM returns to IDLE after result_ready.
REQ-033 SHALL cover result_ready held low 5 cycles: result_valid and result stable, req_ready=0, a new req_valid ignored.
REQ-034 SHALL cover rst_n pulsed low during DATA: all outputs 0 immediately, then req_ready=1 and next request a=7, b=7 returns 49.
REQ-035 SHALL cover MULT_CHECK_EN with a=2, b=4 and m_rdata=9: err=1. Without the macro the same case gives err=0.
